tdm_demux_2ch: RTL and testbench

- Receive-side counterpart of the team's 2:1 selector path.
- Takes one bit-interleaved serial stream, produced by a transmitter that toggles its 2:1 mux select each bit, and splits it back into two parallel channel words.
- Tracks frame sync, reassembles one W-bit word per channel, and presents both words with a one-cycle valid pulse.
- Sits between the serial link input and the per-channel consumers.

---
 rtl/tdm_demux_2ch_if.sv | 25 ++
 rtl/tdm_demux_2ch.sv | 131 +++++++++++++
 tb/tb_tdm_demux_2ch.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux_2ch_if.sv
// rtl/tdm_demux_2ch_if.sv - serial TDM input and demultiplexed channel outputs of tdm_demux_2ch
interface tdm_demux_2ch_if #(
    parameter int W = 8
);
    logic         din;
    logic         en;
    logic         sync;
    logic [W-1:0] y0;
    logic [W-1:0] y1;
    logic         vld;
    logic         err;
    logic         sel;
    logic         busy;
    logic [1:0]   perr;

    modport master (
        output din, en, sync,
        input  y0, y1, vld, err, sel, busy, perr
    );

    modport slave (
        input  din, en, sync,
        output y0, y1, vld, err, sel, busy, perr
    );
endinterface

// File: rtl/tdm_demux_2ch.sv
// rtl/tdm_demux_2ch.sv - 2-channel bit-interleaved TDM demultiplexer with frame sync
// Optional per-channel even parity slots enabled by defining TDM_DEMUX_PARITY_EN.
module tdm_demux_2ch #(
    parameter int W = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    tdm_demux_2ch_if.slave  bus
);
    localparam int KW = (W > 2) ? $clog2(W) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(W - 1);

    typedef enum logic [2:0] {IDLE, RX0, RX1, PAR0, PAR1} state_t;

    state_t        state, state_n;
    logic [KW-1:0] k, k_n;
    logic [W-1:0]  sh0, sh0_n, sh1, sh1_n;
    logic [W-1:0]  y0_q, y0_n, y1_q, y1_n;
    logic          vld_q, vld_n, err_q, err_n;
`ifdef TDM_DEMUX_PARITY_EN
    logic          p0, p0_n;
    logic [1:0]    perr_q, perr_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            sh0   <= '0;
            sh1   <= '0;
            y0_q  <= '0;
            y1_q  <= '0;
            vld_q <= 1'b0;
            err_q <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            p0     <= 1'b0;
            perr_q <= 2'b00;
`endif
        end else begin
            state <= state_n;
            k     <= k_n;
            sh0   <= sh0_n;
            sh1   <= sh1_n;
            y0_q  <= y0_n;
            y1_q  <= y1_n;
            vld_q <= vld_n;
            err_q <= err_n;
`ifdef TDM_DEMUX_PARITY_EN
            p0     <= p0_n;
            perr_q <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        k_n     = k;
        sh0_n   = sh0;
        sh1_n   = sh1;
        y0_n    = y0_q;
        y1_n    = y1_q;
        vld_n   = 1'b0;
        err_n   = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        p0_n    = p0;
        perr_n  = perr_q;
`endif
        if (bus.en) begin
            if (bus.sync) begin
                // A sync always restarts the frame with this bit as ch0 bit 0;
                // it is only an error when it cuts a frame short.
                err_n    = (state != IDLE);
                state_n  = RX1;
                k_n      = '0;
                sh0_n    = '0;
                sh0_n[0] = bus.din;
                sh1_n    = '0;
            end else begin
                case (state)
                    RX0: begin
                        sh0_n[k] = bus.din;
                        state_n  = RX1;
                    end
                    RX1: begin
                        sh1_n[k] = bus.din;
                        if (k == K_LAST) begin
                            k_n = '0;
`ifdef TDM_DEMUX_PARITY_EN
                            state_n = PAR0;
`else
                            state_n = IDLE;
                            y0_n    = sh0;
                            y1_n    = sh1_n;
                            vld_n   = 1'b1;
`endif
                        end else begin
                            k_n     = k + KW'(1);
                            state_n = RX0;
                        end
                    end
`ifdef TDM_DEMUX_PARITY_EN
                    PAR0: begin
                        p0_n    = bus.din;
                        state_n = PAR1;
                    end
                    PAR1: begin
                        state_n = IDLE;
                        y0_n    = sh0;
                        y1_n    = sh1;
                        vld_n   = 1'b1;
                        perr_n  = {^sh1 ^ bus.din, ^sh0 ^ p0};
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

    assign bus.y0   = y0_q;
    assign bus.y1   = y1_q;
    assign bus.vld  = vld_q;
    assign bus.err  = err_q;
    assign bus.sel  = (state == RX1) || (state == PAR1);
    assign bus.busy = (state != IDLE);
`ifdef TDM_DEMUX_PARITY_EN
    assign bus.perr = perr_q;
`else
    assign bus.perr = 2'b00;
`endif
endmodule

// File: tb/tb_tdm_demux_2ch.sv
// tb/tb_tdm_demux_2ch.sv - directed self-checking bench for tdm_demux_2ch (W=8)
module tb_tdm_demux_2ch;
`ifdef TDM_DEMUX_PARITY_EN
    localparam int FL = 18;
`else
    localparam int FL = 16;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;

    tdm_demux_2ch_if #(.W(8)) bus ();

    tdm_demux_2ch #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic bit_in(input logic d, input logic s);
        bus.din  = d;
        bus.sync = s;
        bus.en   = 1'b1;
        @(posedge clk);
        #1;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.en = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input int ga, input int gb, input int gl,
                              input logic pa, input logic pb, input logic exp_err0,
                              output int t_first, output int t_last);
        logic [17:0] bits;
        bits = '0;
        for (int i = 0; i < 8; i++) begin
            bits[2*i]   = a[i];
            bits[2*i+1] = b[i];
        end
        bits[16] = pa;
        bits[17] = pb;
        t_first = 0;
        for (int i = 0; i < FL; i++) begin
            if (!(i == 0 && exp_err0)) check("sel", bus.sel, i % 2);
            bit_in(bits[i], i == 0);
            if (i == 0) begin
                t_first = cyc;
                check("err_first", bus.err, exp_err0);
                check("busy_first", bus.busy, 1);
            end else begin
                check("err", bus.err, 0);
            end
            if (i < FL - 1) check("vld_early", bus.vld, 0);
            if (i == ga || i == gb) idle(gl);
        end
        t_last = cyc;
    endtask

    int t0, t1, ta;
    logic [7:0] va, vb;

    initial begin
        rst_n    = 1'b0;
        bus.din  = 1'b0;
        bus.en   = 1'b0;
        bus.sync = 1'b0;
        idle(2);
        check("rst_y0", bus.y0, 0);
        check("rst_y1", bus.y1, 0);
        check("rst_vld", bus.vld, 0);
        check("rst_err", bus.err, 0);
        check("rst_sel", bus.sel, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_perr", bus.perr, 0);
        rst_n = 1'b1;
        idle(2);

        // 1: continuous frame
        va = 8'hA5; vb = 8'h3C;
        send_frame(va, vb, -1, -1, 0, ^va, ^vb, 1'b0, t0, t1);
        check("t1_vld", bus.vld, 1);
        check("t1_y0", bus.y0, 8'hA5);
        check("t1_y1", bus.y1, 8'h3C);
        check("t1_busy", bus.busy, 0);
        check("t1_perr", bus.perr, 0);
        check("t1_lat", t1 - t0, FL - 1);
        idle(1);
        check("t1_vld_pulse", bus.vld, 0);
        check("t1_y0_hold", bus.y0, 8'hA5);

        // 2: same frame with two 3-cycle gaps
        send_frame(va, vb, 5, 11, 3, ^va, ^vb, 1'b0, t0, t1);
        check("t2_vld", bus.vld, 1);
        check("t2_y0", bus.y0, 8'hA5);
        check("t2_y1", bus.y1, 8'h3C);
        check("t2_lat", t1 - t0, FL - 1 + 6);
        idle(2);

        // 3: back-to-back frames
        va = 8'h12; vb = 8'h34;
        send_frame(va, vb, -1, -1, 0, ^va, ^vb, 1'b0, t0, t1);
        check("t3a_vld", bus.vld, 1);
        check("t3a_y0", bus.y0, 8'h12);
        check("t3a_y1", bus.y1, 8'h34);
        ta = t1;
        va = 8'hFF; vb = 8'h00;
        send_frame(va, vb, -1, -1, 0, ^va, ^vb, 1'b0, t0, t1);
        check("t3b_vld", bus.vld, 1);
        check("t3b_gap", t1 - ta, FL);
        check("t3b_y0", bus.y0, 8'hFF);
        check("t3b_y1", bus.y1, 8'h00);
        idle(2);

        // 4: unexpected sync after 7 bits
        for (int i = 0; i < 7; i++) bit_in(i[0], i == 0);
        check("t4_busy", bus.busy, 1);
        va = 8'h5A; vb = 8'hC3;
        send_frame(va, vb, -1, -1, 0, ^va, ^vb, 1'b1, t0, t1);
        check("t4_vld", bus.vld, 1);
        check("t4_y0", bus.y0, 8'h5A);
        check("t4_y1", bus.y1, 8'hC3);
        idle(1);
        check("t4_err_quiet", bus.err, 0);

        // 5: reset mid-frame
        for (int i = 0; i < 9; i++) bit_in(~i[0], i == 0);
        check("t5_sel_pre", bus.sel, 1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_y0", bus.y0, 0);
        check("t5_rst_y1", bus.y1, 0);
        check("t5_rst_sel", bus.sel, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_vld", bus.vld, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        check("t5_vld_none", bus.vld, 0);
        va = 8'h01; vb = 8'h80;
        send_frame(va, vb, -1, -1, 0, ^va, ^vb, 1'b0, t0, t1);
        check("t5_vld", bus.vld, 1);
        check("t5_y0", bus.y0, 8'h01);
        check("t5_y1", bus.y1, 8'h80);
        idle(2);

        // 6: parity slots both 0: ch0 wrong (odd data), ch1 right
        va = 8'h07; vb = 8'h03;
        send_frame(va, vb, -1, -1, 0, 1'b0, 1'b0, 1'b0, t0, t1);
        check("t6_vld", bus.vld, 1);
        check("t6_y0", bus.y0, 8'h07);
        check("t6_y1", bus.y1, 8'h03);
`ifdef TDM_DEMUX_PARITY_EN
        check("t6_perr", bus.perr, 2'b01);
`else
        check("t6_perr", bus.perr, 2'b00);
`endif
        idle(1);
`ifdef TDM_DEMUX_PARITY_EN
        check("t6_perr_hold", bus.perr, 2'b01);
`else
        check("t6_perr_hold", bus.perr, 2'b00);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
